// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative AES key schedule for 128/192/256-bit cipher keys.
//
// Expands the cipher key one 32-bit word per clock into a round-key store of
// NR+1 128-bit round keys. A registered random-access port then serves them.
//
// Ports
//   CLK          clock, rising edge
//   RST_N        asynchronous active-low reset
//   START        start-expansion request, sampled on CLK
//   K_I          cipher key, K_I[KEY_BITS-1 -: 32] is w0
//   DEC          (only with KS_DEC_ORDER_EN) 1 = read rounds in decryption order
//   RK_ADDR      round index to read
//   BUSY         expansion in progress
//   DONE         complete schedule held in store (level)
//   RK_O         round key, registered; RK_O[127:96] = w[4r]
//   dbg_state_o  FSM state (0 = IDLE, 1 = EXPAND)
//
// Optional feature macro: KS_DEC_ORDER_EN adds the DEC input.
//
// Handshake: START is a request with no ready. It is accepted on any edge where
// the FSM is IDLE (BUSY=0) and ignored while BUSY=1. Once accepted, BUSY stays
// high for exactly TOTAL cycles and DONE rises on the edge BUSY falls.

module aes_key_sched #(
    parameter int KEY_BITS = 128
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic [KEY_BITS-1:0] K_I,
`ifdef KS_DEC_ORDER_EN
    input  logic                DEC,
`endif
    input  logic [3:0]          RK_ADDR,
    output logic                BUSY,
    output logic                DONE,
    output logic [127:0]        RK_O,
    output logic                dbg_state_o
);

    localparam int NK    = KEY_BITS / 32;
    localparam int NR    = NK + 6;
    localparam int TOTAL = 4 * (NR + 1);

    localparam logic [5:0] NK_W      = 6'(NK);
    localparam logic [5:0] LAST_W    = 6'(TOTAL - 1);
    localparam logic [2:0] NK_LAST_J = 3'(NK - 1);
    localparam logic [3:0] NR_R      = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_sched: KEY_BITS must be 128, 192 or 256");
    end

    // AES S-box, byte 0x00 in the top 8 bits.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] top;
        // 2047 - 8*b is the bitwise complement of {b,3'b0} in 11 bits
        top = ~{b, 3'b000};
        return SBOX[top -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    i_q, i_d;          // index of the word written this cycle
    logic [2:0]    j_q, j_d;          // i mod NK, wraps instead of dividing
    logic [7:0]    rcon_q, rcon_d;
    logic          done_q, done_d;
    logic [127:0]  rk_q, rk_d;
    // Sliding window of the last NK words: win_q[0] = w[i-NK], win_q[NK-1] = w[i-1].
    // During the first NK cycles it rotates the loaded key so win_q[0] = w[i].
    logic [31:0]   win_q [NK];
    logic [31:0]   win_d [NK];
    logic [31:0]   mem_q [TOTAL];

    logic          wr_en;
    logic [31:0]   new_word;
    logic [31:0]   prev_word;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [3:0]    rd_round;
    logic [5:0]    rd_idx;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (START) state_d = ST_EXPAND;
            ST_EXPAND: if (i_q == LAST_W) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        BUSY        = (state_q == ST_EXPAND);
        wr_en       = (state_q == ST_EXPAND);
        dbg_state_o = state_q;
        DONE        = done_q;
        RK_O        = rk_q;
    end

    // ---------------- expansion datapath ----------------
    always_comb begin
        prev_word = win_q[NK-1];
        sub_in    = (j_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        sub_out   = sub_word(sub_in);
        if (i_q < NK_W) begin
            new_word = win_q[0];
        end else if (j_q == 3'd0) begin
            new_word = win_q[0] ^ sub_out ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && j_q == 3'd4) begin
            new_word = win_q[0] ^ sub_out;
        end else begin
            new_word = win_q[0] ^ prev_word;
        end
    end

    always_comb begin
        win_d  = win_q;
        i_d    = i_q;
        j_d    = j_q;
        rcon_d = rcon_q;
        done_d = done_q;
        if (state_q == ST_IDLE) begin
            if (START) begin
                for (int k = 0; k < NK; k++) begin
                    win_d[k] = K_I[KEY_BITS-1-32*k -: 32];
                end
                i_d    = 6'd0;
                j_d    = 3'd0;
                rcon_d = 8'h01;
                done_d = 1'b0;
            end
        end else begin
            for (int k = 0; k < NK - 1; k++) begin
                win_d[k] = win_q[k+1];
            end
            win_d[NK-1] = new_word;
            i_d = i_q + 6'd1;
            j_d = (j_q == NK_LAST_J) ? 3'd0 : j_q + 3'd1;
            if (i_q >= NK_W && j_q == 3'd0) begin
                rcon_d = xtime(rcon_q);
            end
            if (i_q == LAST_W) begin
                i_d    = 6'd0;
                done_d = 1'b1;
            end
        end
    end

    // ---------------- read port ----------------
    // The word being written this edge is forwarded, so a read sampled on the
    // DONE edge already sees the final word of the last round.
    always_comb begin
        rd_round = RK_ADDR;
`ifdef KS_DEC_ORDER_EN
        if (DEC) rd_round = NR_R - RK_ADDR;
`endif
        rd_idx = 6'd0;
        rk_d   = '0;
        if (RK_ADDR <= NR_R) begin
            for (int k = 0; k < 4; k++) begin
                rd_idx = {rd_round, 2'(k)};
                if (wr_en && rd_idx == i_q) begin
                    rk_d[127-32*k -: 32] = new_word;
                end else begin
                    rk_d[127-32*k -: 32] = mem_q[rd_idx];
                end
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            i_q    <= 6'd0;
            j_q    <= 3'd0;
            rcon_q <= 8'h01;
            done_q <= 1'b0;
            rk_q   <= '0;
            for (int k = 0; k < NK; k++) begin
                win_q[k] <= 32'h0;
            end
        end else begin
            i_q    <= i_d;
            j_q    <= j_d;
            rcon_q <= rcon_d;
            done_q <= done_d;
            rk_q   <= rk_d;
            win_q  <= win_d;
        end
    end

    // Round-key store keeps its contents across reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[i_q] <= new_word;
        end
    end

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

Iterative, parametrised AES key schedule for 128-, 192- and 256-bit keys. Expands a cipher key one 32-bit word per clock into an internal round-key store of Nr+1 128-bit round keys, then serves them through a registered random-access read port. Sits beside the round datapath and replaces the per-round combinational expansion: the cipher controller starts it once per key and reads round r by address.

## Interface
- KEY_BITS, 128, cipher key length; legal values 128/192/256, any other value is an elaboration error
- Derived (localparam): NK = KEY_BITS/32; NR = NK+6; TOTAL = 4*(NR+1) words (44/52/60)
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  start-expansion request, sampled on CLK
- K_I  in  KEY_BITS  cipher key; K_I[KEY_BITS-1 -: 32] is w0, K_I[31:0] is w[NK-1]
- BUSY  out  1  expansion in progress
- DONE  out  1  full schedule valid in store (level)
- RK_ADDR  in  4  round index r to read
- RK_O  out  128  round key r; RK_O[127:96] = w[4r], RK_O[31:0] = w[4r+3]

## Operation
- States: IDLE, EXPAND. Reset -> IDLE, BUSY=0, DONE=0, RK_O=0, word counter i=0, Rcon=0x01. Store contents not cleared.
- IDLE: START=1 at an edge -> capture K_I into NK-word sliding window, i=0, Rcon=0x01, DONE=0, BUSY=1, go EXPAND.
- EXPAND: each edge writes one word w[i] into store, i increments.
  - i < NK: w[i] = key word i.
  - i >= NK: temp = w[i-1]; if i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}, then Rcon = xtime(Rcon) (0x80 -> 0x1b); else if NK == 8 and i mod NK == 4: temp = SubWord(temp). w[i] = w[i-NK] ^ temp.
  - RotWord is left rotate by one byte; SubWord applies the AES S-box to each byte (existing SUBWORD).
  - Mod-NK tracked by a separate wrapping counter, no divider.
- Word TOTAL-1 written -> BUSY=0, DONE=1, go IDLE.
- START while BUSY: ignored. START while DONE=1 in IDLE: new expansion, DONE drops.
- Read port: RK_O registered from RK_ADDR every cycle regardless of state; RK_ADDR > NR -> RK_O = 0. Reads while DONE=0 return stale/partial contents; caller must wait for DONE.
- Reset asserted mid-expansion: immediate return to IDLE, BUSY=0, DONE=0; restart requires new START.

## Timing
- START accepted at edge T0; w[k] written at edge T(k+1); BUSY high from after T0 through T(TOTAL); DONE rises and BUSY falls at edge T(TOTAL) (T44/T52/T60).
- START-to-DONE latency: TOTAL cycles. Earliest next START: first edge with BUSY=0.
- Read latency: 1 cycle (RK_ADDR at edge t -> RK_O valid after edge t). A read issued at the DONE edge returns the complete key.
- No combinational path from any input to any output.

## Configuration
- KS_DEC_ORDER_EN defined: extra input DEC (1 bit); when DEC=1, RK_ADDR = r returns round NR-r (decryption order), RK_ADDR > NR still returns 0; DEC=0 behaves as normal.
- Undefined: no DEC port; RK_ADDR always maps directly to round r.

## Test plan
- KEY_BITS=128, K_I=2b7e151628aed2a6abf7158809cf4f3c, START pulse -> DONE after 44 cycles; r=1 -> a0fafe1788542cb123a339392a6c7605; r=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; r=0 -> key itself; r=11 -> 0.
- KEY_BITS=192, K_I=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> DONE after 52 cycles; r=12 -> e98ba06f448c773c8ecc720401002202.
- KEY_BITS=256, K_I=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> DONE after 60 cycles; r=14 -> fe4890d1e6188d0b046df344706c631e (checks i mod 8 == 4 SubWord path).
- KEY_BITS=128: START again at cycle 20 of expansion -> ignored, DONE at cycle 44 with original results; then START with new key -> DONE drops next cycle, new schedule matches model.
- RST_N low at cycle 10 of expansion -> BUSY=0, DONE=0, RK_O=0 immediately; START after release -> correct schedule, DONE after 44 cycles.
- KS_DEC_ORDER_EN defined, KEY_BITS=128 FIPS key, DEC=1, r=0 -> d014f9a8c9ee2589e13f0cc8b6630ca6; r=10 -> 2b7e151628aed2a6abf7158809cf4f3c.
